// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch path and other pipeline blocks.
//   NOP_INS       : instruction word ID sees when nothing is valid
//   RESET_PC      : PC that IF restarts from after reset
//   fetch_entry_t : one fetched word as queued between IF and ID
package cpu_pkg;

  localparam logic [31:0] NOP_INS  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        exc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   clear           : drop all entries (rptr jumps to wptr); overrides push/pop
//   push, wdata     : write wdata at the tail
//   pop             : retire the head entry
//   rdata           : head entry (undefined when empty)
//   count           : number of valid entries
//   full, empty     : status flags
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      rptr_q  <= wptr_q;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  assign rdata = mem[rptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) do_push |-> (!full || do_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) do_pop |-> !empty);

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between the AXI fetch front end (IF) and the ID decoder.
// Hands out fetch credits so the queue cannot overflow, drops responses that
// were in flight when a flush hit, and presents one entry per cycle to ID.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   flush                         : discard queued and in-flight instructions
//   fetch_req_valid/fetch_req_sent: credit to IF / IF consumed a credit
//   resp_valid/ins/pc/exc         : fetch response from IF
//   id_stall                      : ID cannot take the head this cycle
//   id_valid/ins/pc/exc           : head entry, zeroed when empty
//   occupancy                     : queued entry count
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  output logic             fetch_req_valid,
  input  logic             fetch_req_sent,
  input  logic             resp_valid,
  input  logic [31:0]      resp_ins,
  input  logic [31:0]      resp_pc,
  input  logic             resp_exc,
  input  logic             id_stall,
  output logic             id_valid,
  output logic [31:0]      id_ins,
  output logic [31:0]      id_pc,
  output logic             id_exc,
  output logic [PTR_W:0]   occupancy
);

  localparam int unsigned    EW      = $bits(fetch_entry_t);
  localparam logic [PTR_W:0] CNT_ONE = 1;

  logic [PTR_W:0]   outstanding_q, outstanding_d;
  logic [PTR_W:0]   drop_cnt_q, drop_cnt_d;
  logic [PTR_W+1:0] credit_used;
  logic             push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]    fifo_rdata;
  fetch_entry_t     wr_entry, head;

  assign push     = resp_valid & ~flush & (drop_cnt_q == '0);
  assign pop      = id_valid & ~id_stall & ~flush;
  assign wr_entry = '{ins: resp_ins, pc: resp_pc, exc: resp_exc};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (fifo_rdata),
    .count (occupancy),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Words still waiting to be dropped stay in outstanding, so they keep
  // holding their credit until they actually return.
  assign credit_used     = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign fetch_req_valid = (credit_used < (PTR_W + 2)'(DEPTH));

  always_comb begin
    outstanding_d = outstanding_q;
    if (fetch_req_sent && !resp_valid) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (!fetch_req_sent && resp_valid) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end

    // On flush every word already in flight is stale. outstanding_q already
    // counts any words still pending from an earlier flush, so it alone is the
    // new drop total; the word returning this cycle is discarded right away,
    // and a request sent this cycle belongs to the new stream.
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      drop_cnt_d = resp_valid ? outstanding_q - CNT_ONE : outstanding_q;
    end else if (resp_valid && drop_cnt_q != '0) begin
      drop_cnt_d = drop_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign head     = fetch_entry_t'(fifo_rdata);
  assign id_valid = ~fifo_empty;
  assign id_ins   = id_valid ? head.ins : NOP_INS;
  assign id_pc    = id_valid ? head.pc : 32'h0;
  assign id_exc   = id_valid & head.exc;

  a_push_not_full: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a directed vector table, a few
// multi-cycle corner sequences, then randomized traffic against a queue model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, fetch_req_sent, resp_valid, resp_exc, id_stall;
  logic [31:0] resp_ins, resp_pc;
  logic        fetch_req_valid, id_valid, id_exc;
  logic [31:0] id_ins, id_pc;
  logic [2:0]  occupancy;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_sent  (fetch_req_sent),
    .resp_valid      (resp_valid),
    .resp_ins        (resp_ins),
    .resp_pc         (resp_pc),
    .resp_exc        (resp_exc),
    .id_stall        (id_stall),
    .id_valid        (id_valid),
    .id_ins          (id_ins),
    .id_pc           (id_pc),
    .id_exc          (id_exc),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: queued entries, plus one flag per in-flight request
  // telling whether its response is stale (requested before a flush).
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        exc;
  } ent_t;
  ent_t q[$];
  bit   inflight[$];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit f, input bit s, input bit rv, input logic [31:0] ins,
                       input logic [31:0] pc, input bit exc, input bit stall);
    flush          = f;
    fetch_req_sent = s;
    resp_valid     = rv;
    resp_ins       = ins;
    resp_pc        = pc;
    resp_exc       = exc;
    id_stall       = stall;
  endtask

  task automatic model_update();
    bit pop_e, keep, stale;
    pop_e = (q.size() > 0) && !id_stall && !flush;
    keep  = 1'b0;
    if (resp_valid) begin
      if (inflight.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL stimulus: response with nothing in flight (t=%0t)", $time);
      end else begin
        stale = inflight.pop_front();
        keep  = !stale && !flush;
      end
    end
    if (pop_e) void'(q.pop_front());
    if (flush) begin
      q.delete();
      foreach (inflight[i]) inflight[i] = 1'b1;
    end
    if (keep) q.push_back('{ins: resp_ins, pc: resp_pc, exc: resp_exc});
    if (fetch_req_sent) inflight.push_back(1'b0);
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    bit v;
    v = (q.size() > 0);
    chk({tag, ".id_valid"}, id_valid, v);
    chk({tag, ".id_ins"}, id_ins, v ? q[0].ins : 32'h0);
    chk({tag, ".id_pc"}, id_pc, v ? q[0].pc : 32'h0);
    chk({tag, ".id_exc"}, id_exc, v ? q[0].exc : 1'b0);
    chk({tag, ".fetch_req_valid"}, fetch_req_valid, (q.size() + inflight.size()) < DEPTH);
    chk({tag, ".occupancy"}, occupancy, q.size());
  endtask

  typedef struct {
    bit          sent;
    bit          rv;
    logic [31:0] ins;
    logic [31:0] pc;
    bit          e_valid;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    bit          e_frv;
    int          e_occ;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    logic [31:0] wa[4];
    bit          f, s, rv, credit;

    // Streaming: each word shows up one cycle after its response, in order.
    vt[0] = '{1, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 0};
    vt[1] = '{1, 1, 32'h24010001, 32'hbfc00000, 1, 32'h24010001, 32'hbfc00000, 1, 1};
    vt[2] = '{1, 1, 32'h24020002, 32'hbfc00004, 1, 32'h24020002, 32'hbfc00004, 1, 1};
    vt[3] = '{1, 1, 32'h24030003, 32'hbfc00008, 1, 32'h24030003, 32'hbfc00008, 1, 1};
    vt[4] = '{0, 1, 32'h24040004, 32'hbfc0000c, 1, 32'h24040004, 32'hbfc0000c, 1, 1};
    vt[5] = '{0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        1, 0};
    wa    = '{32'h3c011111, 32'h3c022222, 32'h3c033333, 32'h3c044444};

    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.id_valid", id_valid, 0);
    chk("reset.id_ins", id_ins, 0);
    chk("reset.id_pc", id_pc, 0);
    chk("reset.id_exc", id_exc, 0);
    chk("reset.fetch_req_valid", fetch_req_valid, 1);
    chk("reset.occupancy", occupancy, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive(0, vt[i].sent, vt[i].rv, vt[i].ins, vt[i].pc, 0, 0);
      step();
      chk($sformatf("vec%0d.id_valid", i), id_valid, vt[i].e_valid);
      chk($sformatf("vec%0d.id_ins", i), id_ins, vt[i].e_ins);
      chk($sformatf("vec%0d.id_pc", i), id_pc, vt[i].e_pc);
      chk($sformatf("vec%0d.fetch_req_valid", i), fetch_req_valid, vt[i].e_frv);
      chk($sformatf("vec%0d.occupancy", i), occupancy, vt[i].e_occ);
    end

    // Stalled ID: queue fills, credits run out, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 32'h0, 0, 1);
      step();
    end
    chk("stall.credits_exhausted", fetch_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, wa[i], 32'hbfc00100 + 32'(i * 4), 0, 1);
      step();
      check_model("stall_fill");
    end
    chk("stall.occupancy_full", occupancy, 4);
    chk("stall.full_no_credit", fetch_req_valid, 0);
    chk("stall.head", id_ins, wa[0]);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
      step();
      check_model("stall_drain");
      if (i < 4) chk($sformatf("stall.drain%0d", i), id_ins, wa[i]);
    end
    chk("stall.drained_valid", id_valid, 0);
    chk("stall.credit_back", fetch_req_valid, 1);

    // Flush with 3 requests in flight and 1 entry queued.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 32'h0, 0, 1);
      step();
    end
    drive(0, 0, 1, 32'h24110011, 32'hbfc00200, 0, 1);
    step();
    chk("flush.pre_occ", occupancy, 1);
    drive(1, 0, 0, 32'h0, 32'h0, 0, 0);
    step();
    chk("flush.id_valid", id_valid, 0);
    chk("flush.occupancy", occupancy, 0);
    chk("flush.drop_cnt", dut.drop_cnt_q, 3);
    check_model("flush");
    drive(0, 1, 0, 32'h0, 32'h0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 32'hdead0000 + 32'(i), 32'hbfc00204 + 32'(i * 4), 0, 0);
      step();
      chk($sformatf("flush.stale%0d_dropped", i), id_valid, 0);
    end
    drive(0, 0, 1, 32'h00000000, 32'hbfc00380, 0, 1);
    step();
    chk("flush.new_valid", id_valid, 1);
    chk("flush.new_pc", id_pc, 32'hbfc00380);
    chk("flush.new_ins", id_ins, 32'h0);
    check_model("flush_new");
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step();
    check_model("flush_pop");

    // Flush, stale response and new request all in one cycle.
    drive(0, 1, 0, 32'h0, 32'h0, 0, 0);
    step();
    drive(1, 1, 1, 32'hbad00bad, 32'hbfc00500, 0, 0);
    step();
    chk("flush_same.dropped", id_valid, 0);
    chk("flush_same.drop_cnt", dut.drop_cnt_q, 0);
    drive(0, 0, 1, 32'h24050005, 32'hbfc00400, 0, 0);
    step();
    chk("flush_same.new_valid", id_valid, 1);
    chk("flush_same.new_ins", id_ins, 32'h24050005);
    check_model("flush_same");
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step();

    // Fetch exception travels with its entry.
    drive(0, 1, 0, 32'h0, 32'h0, 0, 0);
    step();
    drive(0, 0, 1, 32'h0, 32'hbfc00002, 1, 0);
    step();
    chk("exc.id_exc", id_exc, 1);
    chk("exc.id_pc", id_pc, 32'hbfc00002);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step();
    chk("exc.popped", id_valid, 0);
    chk("exc.cleared", id_exc, 0);

    // Reset mid-stream: 2 queued, 2 outstanding.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0, 32'h0, 0, 1);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, wa[i], 32'hbfc00600 + 32'(i * 4), 0, 1);
      step();
    end
    chk("rst_mid.pre_occ", occupancy, 2);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.id_valid", id_valid, 0);
    chk("rst_mid.id_ins", id_ins, 0);
    chk("rst_mid.id_pc", id_pc, 0);
    chk("rst_mid.occupancy", occupancy, 0);
    q.delete();
    inflight.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step();
    chk("rst_mid.credit", fetch_req_valid, 1);
    check_model("rst_mid");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      credit = (q.size() + inflight.size()) < DEPTH;
      f      = ($urandom_range(15) == 0);
      s      = credit && ($urandom_range(1) == 1);
      rv     = (inflight.size() > 0) && ($urandom_range(2) != 0);
      drive(f, s, rv, $urandom, $urandom & 32'hffff_fffc, $urandom_range(7) == 0,
            $urandom_range(2) == 0);
      step();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
